// File: rtl/thread_dcache.sv
// Direct-mapped, write-through, one-word-line data cache with a single outstanding
// memory transaction; misses and busy-time stores are reported for thread replay.
module thread_dcache #(
   parameter int unsigned LINES      = 16,
   parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wr_data,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [2:0]  d_trd,
   output logic [31:0] d_rd_data,
   output logic        d_miss,
   output logic        d_segfault,
   output logic        fill_done,
   output logic [2:0]  fill_trd,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wr_data,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rd_data
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 32 - IW - 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   logic [1:0]    state_q;
   logic [31:0]   req_addr;
   logic [31:0]   req_data;
   logic [2:0]    req_trd;

   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   logic [31:0] rd_data_q;
   logic        miss_q;
   logic        segfault_q;
   logic        fill_done_q;
   logic [2:0]  fill_trd_q;

   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic          req;
   logic          seg;
   logic          hit;

   always_comb begin
      idx     = d_addr[IW+1:2];
      tag     = d_addr[31:IW+2];
      req_idx = req_addr[IW+1:2];
      req_tag = req_addr[31:IW+2];
      req     = d_rd | d_wr;
      seg     = (d_addr[1:0] != 2'b00) || (d_addr >= ADDR_LIMIT) || (d_rd && d_wr);
      hit     = valid_q[idx] && (tag_q[idx] == tag);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         req_addr    <= '0;
         req_data    <= '0;
         req_trd     <= '0;
         rd_data_q   <= '0;
         miss_q      <= 1'b0;
         segfault_q  <= 1'b0;
         fill_done_q <= 1'b0;
         fill_trd_q  <= '0;
      end else begin
         miss_q      <= 1'b0;
         segfault_q  <= 1'b0;
         fill_done_q <= 1'b0;

         // Requests see the array as it stood before any fill landing this cycle.
         if (req) begin
            if (seg) begin
               segfault_q <= 1'b1;
            end else if (d_rd) begin
               if (hit) begin
                  rd_data_q <= data_q[idx];
               end else begin
                  miss_q <= 1'b1;
                  if (state_q == ST_IDLE) begin
                     state_q  <= ST_FILL;
                     req_addr <= {d_addr[31:2], 2'b00};
                     req_trd  <= d_trd;
                  end
               end
            end else if (state_q == ST_IDLE) begin
               // Posted store: update on hit, no allocate on miss.
               if (hit) data_q[idx] <= d_wr_data;
               state_q  <= ST_WRITE;
               req_addr <= {d_addr[31:2], 2'b00};
               req_data <= d_wr_data;
               req_trd  <= d_trd;
            end else begin
               miss_q <= 1'b1;
            end
         end

         if (state_q == ST_FILL && mem_rdy) begin
            valid_q[req_idx] <= 1'b1;
            tag_q[req_idx]   <= req_tag;
            data_q[req_idx]  <= mem_rd_data;
            fill_done_q      <= 1'b1;
            fill_trd_q       <= req_trd;
            state_q          <= ST_IDLE;
         end

         if (state_q == ST_WRITE && mem_rdy) state_q <= ST_IDLE;
      end
   end

   always_comb begin
      d_rd_data   = rd_data_q;
      d_miss      = miss_q;
      d_segfault  = segfault_q;
      fill_done   = fill_done_q;
      fill_trd    = fill_trd_q;
      mem_addr    = req_addr;
      mem_wr_data = req_data;
      mem_rd      = (state_q == ST_FILL);
      mem_wr      = (state_q == ST_WRITE);
   end

endmodule

// File: tb/tb_thread_dcache.sv
// Self-checking bench for thread_dcache: directed scenarios plus a randomized run
// against a transaction-level cache/memory model.
module tb_thread_dcache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d_addr, d_wr_data;
   logic        d_rd, d_wr;
   logic [2:0]  d_trd;
   logic [31:0] d_rd_data;
   logic        d_miss, d_segfault, fill_done;
   logic [2:0]  fill_trd;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
   logic        mem_rd, mem_wr, mem_rdy;

   int tests = 0;
   int fails = 0;

   thread_dcache #(.LINES(16), .ADDR_LIMIT(32'h0001_0000)) dut (
      .clk(clk), .rst(rst), .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd),
      .d_wr(d_wr), .d_trd(d_trd), .d_rd_data(d_rd_data), .d_miss(d_miss),
      .d_segfault(d_segfault), .fill_done(fill_done), .fill_trd(fill_trd),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
      .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] t);
      d_rd = rd; d_wr = wr; d_addr = a; d_wr_data = wd; d_trd = t;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
   endtask

   task automatic do_reset();
      idle();
      mem_rdy = 1'b0; mem_rd_data = 32'h0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Read miss on an idle cache, memory answers one cycle later; leaves bench in fill_done cycle.
   task automatic fill(input logic [31:0] a, input logic [31:0] data, input logic [2:0] t);
      drive(1'b1, 1'b0, a, 32'h0, t);
      tick();
      idle();
      mem_rdy = 1'b1; mem_rd_data = data;
      tick();
      mem_rdy = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({d_rd_data, d_miss, d_segfault, fill_done, fill_trd, mem_addr, mem_rd, mem_wr,
           mem_wr_data} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: rd_data=%h miss=%b seg=%b fd=%b ftrd=%0d maddr=%h mrd=%b mwr=%b mwd=%h, want all 0",
                  d_rd_data, d_miss, d_segfault, fill_done, fill_trd, mem_addr, mem_rd, mem_wr,
                  mem_wr_data);
      end
   endtask

   task automatic test_miss_hit();
      do_reset();
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd2);
      tick();
      idle();
      tests++;
      if ({d_miss, mem_rd, mem_addr} !== {1'b1, 1'b1, 32'h40}) begin
         fails++;
         $display("FAIL miss_start: miss=%b mem_rd=%b mem_addr=%h, want 1 1 00000040",
                  d_miss, mem_rd, mem_addr);
      end
      tick();
      tick();
      tests++;
      if ({d_miss, mem_rd, mem_addr, fill_done} !== {1'b0, 1'b1, 32'h40, 1'b0}) begin
         fails++;
         $display("FAIL miss_wait: miss=%b mem_rd=%b mem_addr=%h fd=%b, want 0 1 00000040 0",
                  d_miss, mem_rd, mem_addr, fill_done);
      end
      mem_rdy = 1'b1; mem_rd_data = 32'hDEADBEEF;
      tick();
      mem_rdy = 1'b0;
      tests++;
      if ({fill_done, fill_trd, mem_rd} !== {1'b1, 3'd2, 1'b0}) begin
         fails++;
         $display("FAIL fill_done: fd=%b trd=%0d mem_rd=%b, want 1 2 0", fill_done, fill_trd, mem_rd);
      end
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd2);
      tick();
      idle();
      tests++;
      if ({d_rd_data, d_miss, fill_done, mem_rd} !== {32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL replay_hit: data=%h miss=%b fd=%b mem_rd=%b, want deadbeef 0 0 0",
                  d_rd_data, d_miss, fill_done, mem_rd);
      end
   endtask

   task automatic test_conflict();
      do_reset();
      fill(32'h40, 32'hAAAA_0040, 3'd1);
      drive(1'b1, 1'b0, 32'h80, 32'h0, 3'd3);
      tick();
      idle();
      tests++;
      if ({d_miss, mem_rd, mem_addr} !== {1'b1, 1'b1, 32'h80}) begin
         fails++;
         $display("FAIL conflict_miss: miss=%b mem_rd=%b mem_addr=%h, want 1 1 00000080",
                  d_miss, mem_rd, mem_addr);
      end
      mem_rdy = 1'b1; mem_rd_data = 32'hBBBB_0080;
      tick();
      mem_rdy = 1'b0;
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd1);
      tick();
      idle();
      tests++;
      if ({d_miss, mem_rd, mem_addr} !== {1'b1, 1'b1, 32'h40}) begin
         fails++;
         $display("FAIL evicted_miss: miss=%b mem_rd=%b mem_addr=%h, want 1 1 00000040",
                  d_miss, mem_rd, mem_addr);
      end
      mem_rdy = 1'b1; mem_rd_data = 32'hAAAA_0040;
      tick();
      mem_rdy = 1'b0;
   endtask

   task automatic test_write_through();
      do_reset();
      fill(32'h40, 32'hDEADBEEF, 3'd0);
      drive(1'b0, 1'b1, 32'h40, 32'h12345678, 3'd4);
      tick();
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd4);
      tests++;
      if ({d_miss, mem_wr, mem_rd, mem_addr, mem_wr_data} !==
          {1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678}) begin
         fails++;
         $display("FAIL store_post: miss=%b mwr=%b mrd=%b maddr=%h mwd=%h, want 0 1 0 00000040 12345678",
                  d_miss, mem_wr, mem_rd, mem_addr, mem_wr_data);
      end
      tick();
      idle();
      mem_rdy = 1'b1;
      tests++;
      if ({d_rd_data, d_miss} !== {32'h12345678, 1'b0}) begin
         fails++;
         $display("FAIL store_readback: data=%h miss=%b, want 12345678 0", d_rd_data, d_miss);
      end
      tick();
      mem_rdy = 1'b0;
      tests++;
      if ({mem_wr, fill_done} !== 2'b00) begin
         fails++;
         $display("FAIL write_done: mwr=%b fd=%b, want 0 0", mem_wr, fill_done);
      end
   endtask

   task automatic test_busy_replay();
      do_reset();
      fill(32'h40, 32'h0000_4040, 3'd0);
      drive(1'b1, 1'b0, 32'hC0, 32'h0, 3'd5);
      tick();
      drive(1'b0, 1'b1, 32'h44, 32'h5555_5555, 3'd6);
      tick();
      tests++;
      if ({d_miss, mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'hC0}) begin
         fails++;
         $display("FAIL busy_store: miss=%b mrd=%b mwr=%b maddr=%h, want 1 1 0 000000c0",
                  d_miss, mem_rd, mem_wr, mem_addr);
      end
      drive(1'b1, 1'b0, 32'h48, 32'h0, 3'd7);
      tick();
      tests++;
      if ({d_miss, mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'hC0}) begin
         fails++;
         $display("FAIL busy_read_miss: miss=%b mrd=%b mwr=%b maddr=%h, want 1 1 0 000000c0",
                  d_miss, mem_rd, mem_wr, mem_addr);
      end
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd1);
      tick();
      idle();
      tests++;
      if ({d_rd_data, d_miss, mem_rd} !== {32'h0000_4040, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL busy_hit: data=%h miss=%b mrd=%b, want 00004040 0 1", d_rd_data, d_miss, mem_rd);
      end
      mem_rdy = 1'b1; mem_rd_data = 32'h0000_C0C0;
      tick();
      mem_rdy = 1'b0;
      drive(1'b1, 1'b0, 32'h44, 32'h0, 3'd6);
      tick();
      idle();
      tests++;
      if ({d_miss, mem_addr} !== {1'b1, 32'h44}) begin
         fails++;
         $display("FAIL busy_store_dropped: miss=%b maddr=%h, want 1 00000044", d_miss, mem_addr);
      end
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
   endtask

   task automatic test_segfault();
      logic [31:0] addrs [3];
      logic        wrs   [3];
      addrs[0] = 32'h42;        wrs[0] = 1'b0;
      addrs[1] = 32'h0001_0000; wrs[1] = 1'b0;
      addrs[2] = 32'h40;        wrs[2] = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, wrs[i], addrs[i], 32'h0, 3'd1);
         tick();
         idle();
         tests++;
         if ({d_segfault, d_miss, mem_rd, mem_wr} !== 4'b1000) begin
            fails++;
            $display("FAIL segfault_%0d: seg=%b miss=%b mrd=%b mwr=%b, want 1 0 0 0",
                     i, d_segfault, d_miss, mem_rd, mem_wr);
         end
         tick();
      end
      tests++;
      if ({d_segfault, mem_rd, mem_wr} !== 3'b000) begin
         fails++;
         $display("FAIL segfault_clear: seg=%b mrd=%b mwr=%b, want 0 0 0", d_segfault, mem_rd, mem_wr);
      end
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      fill(32'h40, 32'h1111_2222, 3'd0);
      drive(1'b1, 1'b0, 32'h80, 32'h0, 3'd3);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({mem_rd, fill_done} !== 2'b00) begin
         fails++;
         $display("FAIL reset_mid_fill: mrd=%b fd=%b, want 0 0", mem_rd, fill_done);
      end
      mem_rdy = 1'b1;
      tick();
      tick();
      mem_rdy = 1'b0;
      tests++;
      if ({mem_rd, fill_done} !== 2'b00) begin
         fails++;
         $display("FAIL reset_no_fill_done: mrd=%b fd=%b, want 0 0", mem_rd, fill_done);
      end
      drive(1'b1, 1'b0, 32'h40, 32'h0, 3'd0);
      tick();
      idle();
      tests++;
      if (d_miss !== 1'b1) begin
         fails++;
         $display("FAIL reset_invalidates: miss=%b, want 1", d_miss);
      end
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
   endtask

   // Reference model: word-level cache contents, a backing-memory map and one pending op.
   logic [31:0] mem_model [int];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_model.exists(int'(a))) return mem_model[int'(a)];
      return a * 32'd2654435761 + 32'h1357;
   endfunction

   task automatic test_random();
      bit          m_valid [16];
      int          m_tag   [16];
      logic [31:0] m_data  [16];
      int          busy;  // 0 none, 1 read pending, 2 write pending
      logic [31:0] p_addr, p_data, e_rd, a, wd;
      logic [2:0]  p_trd, e_ftrd, t;
      logic        e_miss, e_seg, e_fd, rd, wr, rdy, cached;
      int          r, li, lt;
      do_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      busy = 0; p_addr = 0; p_data = 0; p_trd = 0; e_rd = 0; e_ftrd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         r  = $urandom_range(0, 9);
         a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         wd = $urandom;
         t  = 3'($urandom_range(0, 7));
         rd = (r >= 1 && r <= 4) || r == 8;
         wr = (r >= 5 && r <= 7);
         if (r == 8) begin
            case ($urandom_range(0, 2))
               0: a = a | 32'($urandom_range(1, 3));
               1: a = a + 32'h0001_0000 + ($urandom_range(0, 255) << 8);
               default: wr = 1'b1;
            endcase
         end
         rdy = ($urandom_range(0, 2) == 0);
         drive(rd, wr, a, wd, t);
         mem_rdy = rdy;
         mem_rd_data = (busy == 1) ? mem_val(p_addr) : $urandom;

         e_miss = 1'b0; e_seg = 1'b0; e_fd = 1'b0;
         li = int'((a / 4) % 16);
         lt = int'(a / 64);
         cached = m_valid[li] && m_tag[li] == lt;
         if (rd || wr) begin
            if ((a % 4) != 0 || a >= 32'h0001_0000 || (rd && wr)) e_seg = 1'b1;
            else if (rd && cached) e_rd = m_data[li];
            else if (rd) begin
               e_miss = 1'b1;
               if (busy == 0) begin busy = 3; p_addr = a; p_trd = t; end
            end else if (busy == 0) begin
               if (cached) m_data[li] = wd;
               busy = 4; p_addr = a; p_data = wd;
            end else e_miss = 1'b1;
         end
         if (busy == 1 && rdy) begin
            li = int'((p_addr / 4) % 16);
            m_valid[li] = 1'b1; m_tag[li] = int'(p_addr / 64); m_data[li] = mem_val(p_addr);
            e_fd = 1'b1; e_ftrd = p_trd; busy = 0;
         end else if (busy == 2 && rdy) begin
            mem_model[int'(p_addr)] = p_data;
            busy = 0;
         end
         if (busy == 3) busy = 1;
         if (busy == 4) busy = 2;

         tick();
         tests++;
         if ({d_rd_data, d_miss, d_segfault, fill_done, fill_trd, mem_rd, mem_wr, mem_addr,
              mem_wr_data} !== {e_rd, e_miss, e_seg, e_fd, e_ftrd, busy == 1, busy == 2,
              p_addr, p_data}) begin
            fails++;
            $display("FAIL random cyc %0d: got rd=%h miss=%b seg=%b fd=%b ftrd=%0d mrd=%b mwr=%b maddr=%h mwd=%h; want rd=%h miss=%b seg=%b fd=%b ftrd=%0d mrd=%b mwr=%b maddr=%h mwd=%h",
                     cyc, d_rd_data, d_miss, d_segfault, fill_done, fill_trd, mem_rd, mem_wr,
                     mem_addr, mem_wr_data, e_rd, e_miss, e_seg, e_fd, e_ftrd, busy == 1,
                     busy == 2, p_addr, p_data);
         end
      end
      idle();
      mem_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_conflict();
      test_write_through();
      test_busy_replay();
      test_segfault();
      test_reset_mid_fill();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
